reset_seq_pf: RTL and testbench



---
 rtl/reset_seq_pf.sv | 145 ++++++++++++++
 tb/tb_reset_seq_pf.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/reset_seq_pf.sv
// Purpose: fabric reset sequencer; qualifies the external reset, stretches it and releases reset domains one by one.
// Latency: bit k is released SYNC_STAGES+1+STRETCH_CYCLES+k*STAGGER_CYCLES edges after the qualified reset rises.
// Backpressure: none; SW_RST_REQ restarts the stretch and is ignored while the synchroniser is still settling.
//
// Ports:
//   CLK            sequencer clock
//   EXT_RST_N      external reset, async assert, active-low
//   PLL_LOCK       PLL locked
//   SS_BUSY        system services busy (qualifies reset high while init is done)
//   INIT_DONE      device initialisation complete
//   FF_US_RESTORE  Flash*Freeze restore: forces RESET_N_OUT high, holds qualified reset high
//   SW_RST_REQ     synchronous software reset request
//   RESET_N_OUT    per-domain active-low resets, bit 0 released first
//   READY          all domains released by the sequencer
//   STATE          0 RESET, 1 STRETCH, 2 RELEASE, 3 RUN
module reset_seq_pf #(
    parameter int SYNC_STAGES    = 2,
    parameter int NUM_OUTPUTS    = 4,
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGGER_CYCLES = 8
) (
    input  logic                   CLK,
    input  logic                   EXT_RST_N,
    input  logic                   PLL_LOCK,
    input  logic                   SS_BUSY,
    input  logic                   INIT_DONE,
    input  logic                   FF_US_RESTORE,
    input  logic                   SW_RST_REQ,
    output logic [NUM_OUTPUTS-1:0] RESET_N_OUT,
    output logic                   READY,
    output logic [1:0]             STATE
);

    localparam int CNT_MAX = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(NUM_OUTPUTS + 1);

    localparam logic [CW-1:0]          STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
    localparam logic [CW-1:0]          STAGGER_LAST = CW'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
    localparam logic [IW-1:0]          LAST_IDX     = IW'(NUM_OUTPUTS - 1);
    localparam logic [NUM_OUTPUTS-1:0] ALL_ONES     = '1;
    localparam logic [NUM_OUTPUTS-1:0] ONE_HOT0     = NUM_OUTPUTS'(1);
    // With a single domain or no stagger, everything goes out on the stretch terminal edge.
    localparam bit                     SINGLE_STEP  = (NUM_OUTPUTS == 1) || (STAGGER_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    logic                   qrst_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_ok;
    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [IW-1:0]          idx_q;      // index of the most recently released bit
    logic [IW-1:0]          nxt_idx;
    logic [NUM_OUTPUTS-1:0] rel_q;
    logic                   ready_q;

    // Qualified reset: combinational, used as the async clear of every register.
    assign qrst_n = (((EXT_RST_N & PLL_LOCK) | SS_BUSY) & INIT_DONE) | FF_US_RESTORE;

    // De-assertion synchroniser: constant 1 shifted in once the async clear lifts.
    always_ff @(posedge CLK or negedge qrst_n) begin
        if (!qrst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_ok = sync_q[SYNC_STAGES-1];
    assign nxt_idx = idx_q + 1'b1;

    always_ff @(posedge CLK or negedge qrst_n) begin
        if (!qrst_n) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            idx_q   <= '0;
            rel_q   <= '0;
            ready_q <= 1'b0;
        end else if (SW_RST_REQ && (state_q != ST_RESET)) begin
            // Software reset drops every domain and restarts the stretch from zero.
            state_q <= ST_STRETCH;
            cnt_q   <= '0;
            idx_q   <= '0;
            rel_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (sync_ok) begin
                        state_q <= ST_STRETCH;
                        cnt_q   <= '0;
                    end
                end
                ST_STRETCH: begin
                    if (cnt_q == STRETCH_LAST) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        if (SINGLE_STEP) begin
                            rel_q   <= ALL_ONES;
                            ready_q <= 1'b1;
                            state_q <= ST_RUN;
                        end else begin
                            rel_q   <= ONE_HOT0;
                            state_q <= ST_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == STAGGER_LAST) begin
                        cnt_q <= '0;
                        idx_q <= nxt_idx;
                        rel_q <= rel_q | (ONE_HOT0 << nxt_idx);
                        if (nxt_idx == LAST_IDX) begin
                            ready_q <= 1'b1;
                            state_q <= ST_RUN;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    rel_q   <= ALL_ONES;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_RESET;
                end
            endcase
        end
    end

    // Flash*Freeze restore overrides the domain resets without a clock.
    assign RESET_N_OUT = rel_q | {NUM_OUTPUTS{FF_US_RESTORE}};
    assign READY       = ready_q;
    assign STATE       = state_q;

endmodule

// File: tb/tb_reset_seq_pf.sv
// Bench for reset_seq_pf: three parameter sets driven by shared inputs, checked each cycle against
// an arithmetic model of release edges (anchor edge + stretch + k*stagger).
module tb_reset_seq_pf;

    typedef struct packed {
        logic [15:0] rst;
        logic        ready;
        logic [1:0]  st;
    } exp_t;
    typedef exp_t [2:0] exp3_t;

    localparam int P_SS  [3] = '{2, 2, 3};
    localparam int P_N   [3] = '{4, 3, 5};
    localparam int P_STR [3] = '{16, 16, 3};
    localparam int P_STG [3] = '{8, 0, 2};

    logic       CLK = 1'b0;
    logic       EXT_RST_N, PLL_LOCK, SS_BUSY, INIT_DONE, FF_US_RESTORE, SW_RST_REQ;
    logic [3:0] rst0;
    logic [2:0] rst1;
    logic [4:0] rst2;
    logic       rdy0, rdy1, rdy2;
    logic [1:0] st0, st1, st2;
    exp_t       act_c [3];

    int    total = 0;
    int    bad   = 0;
    bit    started = 1'b0;
    exp3_t exp_q [$];
    int    n_edges = 0;
    int    anchor [3];

    always #5 CLK = ~CLK;

    reset_seq_pf #(.SYNC_STAGES(2), .NUM_OUTPUTS(4), .STRETCH_CYCLES(16), .STAGGER_CYCLES(8)) u_dut0 (
        .CLK(CLK), .EXT_RST_N(EXT_RST_N), .PLL_LOCK(PLL_LOCK), .SS_BUSY(SS_BUSY),
        .INIT_DONE(INIT_DONE), .FF_US_RESTORE(FF_US_RESTORE), .SW_RST_REQ(SW_RST_REQ),
        .RESET_N_OUT(rst0), .READY(rdy0), .STATE(st0));

    reset_seq_pf #(.SYNC_STAGES(2), .NUM_OUTPUTS(3), .STRETCH_CYCLES(16), .STAGGER_CYCLES(0)) u_dut1 (
        .CLK(CLK), .EXT_RST_N(EXT_RST_N), .PLL_LOCK(PLL_LOCK), .SS_BUSY(SS_BUSY),
        .INIT_DONE(INIT_DONE), .FF_US_RESTORE(FF_US_RESTORE), .SW_RST_REQ(SW_RST_REQ),
        .RESET_N_OUT(rst1), .READY(rdy1), .STATE(st1));

    reset_seq_pf #(.SYNC_STAGES(3), .NUM_OUTPUTS(5), .STRETCH_CYCLES(3), .STAGGER_CYCLES(2)) u_dut2 (
        .CLK(CLK), .EXT_RST_N(EXT_RST_N), .PLL_LOCK(PLL_LOCK), .SS_BUSY(SS_BUSY),
        .INIT_DONE(INIT_DONE), .FF_US_RESTORE(FF_US_RESTORE), .SW_RST_REQ(SW_RST_REQ),
        .RESET_N_OUT(rst2), .READY(rdy2), .STATE(st2));

    assign act_c[0] = {12'd0, rst0, rdy0, st0};
    assign act_c[1] = {13'd0, rst1, rdy1, st1};
    assign act_c[2] = {11'd0, rst2, rdy2, st2};

    function automatic logic qual();
        return (((EXT_RST_N & PLL_LOCK) | SS_BUSY) & INIT_DONE) | FF_US_RESTORE;
    endfunction

    // Expected outputs after `n` qualified edges, with the stretch starting at edge `anc`.
    function automatic exp_t model(int c, int n, int anc, logic q, logic ff);
        exp_t r;
        int   d;
        r = '0;
        if (q && n >= anc) begin
            d = n - anc;
            for (int k = 0; k < P_N[c]; k++)
                if (d >= P_STR[c] + k * P_STG[c]) r.rst[k] = 1'b1;
            r.ready = (d >= P_STR[c] + (P_N[c] - 1) * P_STG[c]);
            r.st    = r.ready ? 2'd3 : ((d < P_STR[c]) ? 2'd1 : 2'd2);
        end
        if (ff)
            for (int k = 0; k < P_N[c]; k++) r.rst[k] = 1'b1;
        return r;
    endfunction

    task automatic clear_model();
        n_edges = 0;
        for (int c = 0; c < 3; c++) anchor[c] = P_SS[c] + 1;
    endtask

    // Reference model: advances on each edge, re-evaluates after input changes, pushes expectations.
    always @(posedge CLK) begin
        exp3_t e;
        if (qual()) begin
            for (int c = 0; c < 3; c++)
                if (SW_RST_REQ && n_edges >= P_SS[c] + 1) anchor[c] = n_edges + 1;
            n_edges = n_edges + 1;
        end else begin
            clear_model();
        end
        #2;
        if (!qual()) clear_model();
        for (int c = 0; c < 3; c++) e[c] = model(c, n_edges, anchor[c], qual(), FF_US_RESTORE);
        exp_q.push_back(e);
        started = 1'b1;
    end

    // Monitor: mid-cycle, so asynchronous effects are visible before the next edge.
    always @(negedge CLK) begin
        exp3_t e;
        if (started) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL queue_empty t=%0t: no expectation available", $time);
            end else begin
                e = exp_q.pop_front();
                for (int c = 0; c < 3; c++) begin
                    total++;
                    if (act_c[c] !== e[c]) begin
                        bad++;
                        $display("FAIL cfg%0d_outputs t=%0t: got rst=%h ready=%b state=%0d, want rst=%h ready=%b state=%0d",
                                 c, $time, act_c[c].rst, act_c[c].ready, act_c[c].st,
                                 e[c].rst, e[c].ready, e[c].st);
                    end
                end
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        int r;
        clear_model();
        EXT_RST_N = 1'b0; PLL_LOCK = 1'b1; SS_BUSY = 1'b0;
        INIT_DONE = 1'b1; FF_US_RESTORE = 1'b0; SW_RST_REQ = 1'b0;

        // Power-up with defaults.
        cyc(5);
        EXT_RST_N = 1'b1;
        cyc(50);

        // Fresh sequence, then lose PLL lock after two default-config bits are out.
        EXT_RST_N = 1'b0;
        cyc(3);
        EXT_RST_N = 1'b1;
        cyc(30);
        PLL_LOCK = 1'b0;
        cyc(3);
        PLL_LOCK = 1'b1;
        cyc(50);

        // Single-cycle software reset in RUN, then a 5-cycle request.
        SW_RST_REQ = 1'b1;
        cyc(1);
        SW_RST_REQ = 1'b0;
        cyc(45);
        SW_RST_REQ = 1'b1;
        cyc(5);
        SW_RST_REQ = 1'b0;
        cyc(50);

        // Flash*Freeze restore while the external reset is held.
        EXT_RST_N = 1'b0;
        cyc(3);
        FF_US_RESTORE = 1'b1;
        cyc(50);
        FF_US_RESTORE = 1'b0;
        cyc(3);

        // SS_BUSY qualifies reset high; INIT_DONE low overrides it.
        SS_BUSY = 1'b1;
        cyc(50);
        INIT_DONE = 1'b0;
        cyc(5);
        INIT_DONE = 1'b1;
        SS_BUSY   = 1'b0;
        EXT_RST_N = 1'b1;
        cyc(5);

        // Randomised input activity, biased so sequences usually complete.
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 999);
            SW_RST_REQ = (r < 25);
            if (PLL_LOCK) begin
                if ($urandom_range(0, 149) == 0) PLL_LOCK = 1'b0;
            end else if ($urandom_range(0, 3) == 0) PLL_LOCK = 1'b1;
            if (EXT_RST_N) begin
                if ($urandom_range(0, 299) == 0) EXT_RST_N = 1'b0;
            end else if ($urandom_range(0, 2) == 0) EXT_RST_N = 1'b1;
            if (INIT_DONE) begin
                if ($urandom_range(0, 299) == 0) INIT_DONE = 1'b0;
            end else if ($urandom_range(0, 2) == 0) INIT_DONE = 1'b1;
            if (FF_US_RESTORE) begin
                if ($urandom_range(0, 9) == 0) FF_US_RESTORE = 1'b0;
            end else if ($urandom_range(0, 199) == 0) FF_US_RESTORE = 1'b1;
            if ($urandom_range(0, 49) == 0) SS_BUSY = ~SS_BUSY;
            cyc(1);
        end
        SW_RST_REQ = 1'b0;
        cyc(3);

        @(negedge CLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
